data_mem_sized: RTL and testbench
=================================

// Module: data_mem_sized
// PURPOSE
//  Byte-addressed MIPS data memory with one registered read port and one synchronous write port.
//  Supports byte, half and word accesses, with sign- or zero-extension on loads.
//  Detects misaligned accesses and raises a fault.
//  Sits at the MEM stage between the ALU address output and the write-back mux.
// PARAMETERS
//  ADDR_W      32  width of Address/FaultAddr
//  DEPTH_LOG2  5   memory holds 2**DEPTH_LOG2 bytes (min 2)
//  INIT_PAT    1   1: time-zero init mem[i]=i[7:0]; 0: all bytes zero
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       synchronous active-low reset
//  Address      in   ADDR_W  byte address of access
//  WriteData    in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  MemRead      in   1       load request, sampled on clk
//  MemWrite     in   1       store request, sampled on clk
//  MemSize      in   2       00 byte, 01 half, 10 word, 11 reserved
//  MemUnsigned  in   1       1: zero-extend load (lbu/lhu); 0: sign-extend
//  ReadData     out  32      load result, registered
//  ReadValid    out  1       1-cycle pulse: ReadData valid for the load sampled last edge
//  Fault        out  1       1-cycle pulse: access sampled last edge was rejected
//  FaultAddr    out  ADDR_W  Address of the last rejected access; holds until the next fault
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): ReadData=0, ReadValid=0, Fault=0, FaultAddr=0.
//    Memory contents are not cleared; a load in flight is dropped (no ReadValid).
//  - Index = Address[DEPTH_LOG2-1:0]; higher address bits are ignored (wrap modulo depth).
//  - Layout is little-endian: byte k of a word/half lives at index+k.
//  - Alignment: half needs Address[0]=0; word needs Address[1:0]=00.
//    Misaligned or MemSize=11 with MemRead|MemWrite: no memory update, ReadValid=0.
//    Next cycle: Fault=1, FaultAddr=Address, ReadData holds its previous value.
//  - Load latency is 1 cycle: request at edge N gives ReadData/ReadValid after edge N.
//    Byte: data = mem[idx] extended. Half: {mem[idx+1],mem[idx]} extended.
//    Word: the 4 bytes; MemUnsigned is ignored.
//  - Store: bytes written at the edge; only the size's bytes change, the rest are untouched.
//  - MemRead & MemWrite together, same or overlapping bytes: read-first.
//    ReadData returns pre-write contents; the write still takes effect.
//  - Load on the cycle after a store to the same address returns the new data.
//  - MemRead=0: ReadValid=0, and ReadData holds its last value (does not glitch to 0).
//  - No back-pressure: a new access is accepted on every cycle.
// CONFIGURATION
//  BOUNDS_CHECK_EN defined:
//    Any access with Address >= 2**DEPTH_LOG2 is rejected exactly like a misaligned access
//    (Fault, FaultAddr, no update).
//  BOUNDS_CHECK_EN undefined:
//    Upper address bits are ignored and accesses wrap as described above.
// TESTING (DEPTH_LOG2=5, INIT_PAT=1)
//  1. lw Address=0x00 -> after 1 edge: ReadData=0x03020100, ReadValid=1, Fault=0.
//  2. sb 0x80 to 0x05; then lb 0x05 -> 0xFFFFFF80; lbu 0x05 -> 0x00000080.
//     Then lw 0x04 -> 0x07068004 (bytes 4,6,7 untouched).
//  3. sh 0xBEEF to 0x03 -> Fault=1, FaultAddr=0x03; lw 0x00 still returns 0x03020100.
//  4. sw 0xDEADBEEF at 0x08 together with lw 0x08 -> ReadData=0x0B0A0908;
//     next lw 0x08 -> 0xDEADBEEF.
//  5. lw 0x20: without BOUNDS_CHECK_EN -> 0x03020100, no fault;
//     with the macro -> Fault=1, FaultAddr=0x20, ReadValid=0.
//  6. lw 0x00 issued, rst_n=0 on the next edge -> ReadValid=0, ReadData=0.
//     sw 0x11223344 to 0x0C before reset, lw 0x0C after reset -> 0x11223344 (contents kept).

Source files
------------

// File: rtl/data_mem_sized.sv
// ============================================================================
// Module      : data_mem_sized
// Description : Byte-addressed MIPS data memory. It has one registered load port
//               and one synchronous store port, supports byte/half/word sizes and
//               flags misaligned accesses. Optional macro BOUNDS_CHECK_EN rejects
//               addresses outside the array instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_sized #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int INIT_PAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  output logic [31:0]       ReadData,
  output logic              ReadValid,
  output logic              Fault,
  output logic [ADDR_W-1:0] FaultAddr
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [7:0] mem_t [0:c_DEPTH-1];

  function automatic mem_t f_init();
    mem_t m;
    for (int i = 0; i < c_DEPTH; i++) begin
      m[i] = (INIT_PAT != 0) ? 8'(i) : 8'h00;
    end
    return m;
  endfunction

  // Power-up contents come from the declaration; reset never touches the array.
  mem_t r_mem = f_init();

  logic [31:0]           r_rdata;
  logic                  r_rvalid;
  logic                  r_fault;
  logic [ADDR_W-1:0]     r_faddr;

  logic [DEPTH_LOG2-1:0] w_i0, w_i1, w_i2, w_i3;
  logic [7:0]            w_b0, w_b1, w_b2, w_b3;
  logic                  w_req, w_misalign, w_oob, w_reject;
  logic                  w_do_read, w_do_write;
  logic [31:0]           w_load;
  logic                  w_unused;

  assign w_i0 = Address[DEPTH_LOG2-1:0];
  assign w_i1 = w_i0 + DEPTH_LOG2'(1);
  assign w_i2 = w_i0 + DEPTH_LOG2'(2);
  assign w_i3 = w_i0 + DEPTH_LOG2'(3);

  assign w_b0 = r_mem[w_i0];
  assign w_b1 = r_mem[w_i1];
  assign w_b2 = r_mem[w_i2];
  assign w_b3 = r_mem[w_i3];

  assign w_req      = MemRead | MemWrite;
  assign w_misalign = (MemSize == 2'b11)
                    | ((MemSize == 2'b01) & Address[0])
                    | ((MemSize == 2'b10) & (|Address[1:0]));
`ifdef BOUNDS_CHECK_EN
  assign w_oob      = |Address[ADDR_W-1:DEPTH_LOG2];
`else
  assign w_oob      = 1'b0;
`endif
  assign w_unused   = ^Address[ADDR_W-1:DEPTH_LOG2];
  assign w_reject   = w_req & (w_misalign | w_oob);
  assign w_do_read  = MemRead & ~w_reject;
  assign w_do_write = MemWrite & ~w_reject & rst_n;

  always_comb begin
    w_load = '0;
    case (MemSize)
      2'b00:   w_load = {{24{~MemUnsigned & w_b0[7]}}, w_b0};
      2'b01:   w_load = {{16{~MemUnsigned & w_b1[7]}}, w_b1, w_b0};
      default: w_load = {w_b3, w_b2, w_b1, w_b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_fault  <= 1'b0;
      r_faddr  <= '0;
    end else begin
      r_rvalid <= w_do_read;
      r_fault  <= w_reject;
      if (w_reject)  r_faddr <= Address;
      if (w_do_read) r_rdata <= w_load;
    end
  end

  // Reads above sample the array before this edge updates it, giving read-first.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_i0] <= WriteData[7:0];
      if (MemSize != 2'b00) r_mem[w_i1] <= WriteData[15:8];
      if (MemSize == 2'b10) begin
        r_mem[w_i2] <= WriteData[23:16];
        r_mem[w_i3] <= WriteData[31:24];
      end
    end
  end

  assign ReadData  = r_rdata;
  assign ReadValid = r_rvalid;
  assign Fault     = r_fault;
  assign FaultAddr = r_faddr;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_sized.sv
// ============================================================================
// Module      : tb_data_mem_sized
// Description : Bench for data_mem_sized. It runs directed scenarios and then
//               random traffic against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_sized;

  localparam int c_DEPTH = 32;
`ifdef BOUNDS_CHECK_EN
  localparam bit c_BOUNDS = 1'b1;
`else
  localparam bit c_BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address, WriteData;
  logic        MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] ReadData;
  logic        ReadValid, Fault;
  logic [31:0] FaultAddr;

  int checks = 0;
  int failures = 0;

  logic [7:0]  model [c_DEPTH];
  logic [31:0] exp_rdata, exp_faddr;
  logic        exp_rvalid, exp_fault;

  data_mem_sized #(.ADDR_W(32), .DEPTH_LOG2(5), .INIT_PAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .ReadData(ReadData), .ReadValid(ReadValid),
    .Fault(Fault), .FaultAddr(FaultAddr)
  );

  always #5 clk = ~clk;

  // Drives one access and advances the model, then samples 1 time unit past the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                      input logic wr, input logic [1:0] sz, input logic uns,
                      input logic rstn);
    int     nb, idx;
    bit     bad;
    longint v;
    Address = a; WriteData = wd; MemRead = rd; MemWrite = wr;
    MemSize = sz; MemUnsigned = uns; rst_n = rstn;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    idx = int'(a % c_DEPTH);
    bad = (rd || wr) && (sz == 2'd3 || (a % nb) != 0 || (c_BOUNDS && a >= c_DEPTH));
    if (!rstn) begin
      exp_rdata = '0; exp_faddr = '0; exp_rvalid = 1'b0; exp_fault = 1'b0;
    end else begin
      exp_fault  = bad;
      exp_rvalid = rd && !bad;
      if (bad) exp_faddr = a;
      if (rd && !bad) begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v + (longint'(model[(idx + k) % c_DEPTH]) << (8 * k));
        if (nb < 4 && !uns && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (64'sd1 << (8 * nb));
        exp_rdata = v[31:0];
      end
      if (wr && !bad)
        for (int k = 0; k < nb; k++) model[(idx + k) % c_DEPTH] = wd[8 * k +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (ReadData !== 32'h0 || ReadValid !== 1'b0 || Fault !== 1'b0 || FaultAddr !== 32'h0) begin
      failures++;
      $display("FAIL reset: rd=%h rv=%b f=%b fa=%h, want all zero", ReadData, ReadValid, Fault, FaultAddr);
    end
  endtask

  task automatic test_load_init();
    step(32'h00, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'h03020100 || ReadValid !== 1'b1 || Fault !== 1'b0) begin
      failures++;
      $display("FAIL lw_init: rd=%h rv=%b f=%b, want 03020100 1 0", ReadData, ReadValid, Fault);
    end
    step(32'h00, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'h03020100 || ReadValid !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: rd=%h rv=%b, want 03020100 0", ReadData, ReadValid);
    end
  endtask

  task automatic test_byte_store();
    step(32'h05, 32'h80, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    step(32'h05, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'hFFFFFF80 || ReadValid !== 1'b1) begin
      failures++;
      $display("FAIL lb: rd=%h rv=%b, want ffffff80 1", ReadData, ReadValid);
    end
    step(32'h05, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    checks++;
    if (ReadData !== 32'h00000080) begin
      failures++;
      $display("FAIL lbu: rd=%h, want 00000080", ReadData);
    end
    step(32'h04, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'h07068004) begin
      failures++;
      $display("FAIL lw_after_sb: rd=%h, want 07068004", ReadData);
    end
  endtask

  task automatic test_misalign();
    step(32'h03, 32'hBEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    checks++;
    if (Fault !== 1'b1 || FaultAddr !== 32'h03 || ReadValid !== 1'b0 || ReadData !== 32'h07068004) begin
      failures++;
      $display("FAIL sh_misalign: f=%b fa=%h rv=%b rd=%h, want 1 03 0 07068004", Fault, FaultAddr, ReadValid, ReadData);
    end
    step(32'h00, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'h03020100 || Fault !== 1'b0 || FaultAddr !== 32'h03) begin
      failures++;
      $display("FAIL lw_after_fault: rd=%h f=%b fa=%h, want 03020100 0 03", ReadData, Fault, FaultAddr);
    end
  endtask

  task automatic test_read_first();
    step(32'h08, 32'hDEADBEEF, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'h0B0A0908 || ReadValid !== 1'b1) begin
      failures++;
      $display("FAIL read_first: rd=%h rv=%b, want 0b0a0908 1", ReadData, ReadValid);
    end
    step(32'h08, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_after_write: rd=%h, want deadbeef", ReadData);
    end
  endtask

  task automatic test_bounds();
    step(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
`ifdef BOUNDS_CHECK_EN
    if (Fault !== 1'b1 || FaultAddr !== 32'h20 || ReadValid !== 1'b0) begin
      failures++;
      $display("FAIL bounds: f=%b fa=%h rv=%b, want 1 20 0", Fault, FaultAddr, ReadValid);
    end
`else
    if (ReadData !== 32'h03020100 || Fault !== 1'b0 || ReadValid !== 1'b1) begin
      failures++;
      $display("FAIL wrap: rd=%h f=%b rv=%b, want 03020100 0 1", ReadData, Fault, ReadValid);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    step(32'h0C, 32'h11223344, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    step(32'h00, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    step(32'h00, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    checks++;
    if (ReadValid !== 1'b0 || ReadData !== 32'h0 || FaultAddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_inflight: rv=%b rd=%h fa=%h, want 0 0 0", ReadValid, ReadData, FaultAddr);
    end
    step(32'h0C, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    checks++;
    if (ReadData !== 32'h11223344 || ReadValid !== 1'b1) begin
      failures++;
      $display("FAIL mem_kept: rd=%h rv=%b, want 11223344 1", ReadData, ReadValid);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    int          nb;
    for (int n = 0; n < 400; n++) begin
      sz = 2'($urandom_range(0, 3));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
      step(a, $urandom, 1'($urandom), 1'($urandom), sz, 1'($urandom), 1'b1);
      checks++;
      if (ReadValid !== exp_rvalid || Fault !== exp_fault || FaultAddr !== exp_faddr || ReadData !== exp_rdata) begin
        failures++;
        $display("FAIL random[%0d] a=%h sz=%0d: rv=%b f=%b fa=%h rd=%h, want rv=%b f=%b fa=%h rd=%h",
                 n, a, sz, ReadValid, Fault, FaultAddr, ReadData, exp_rvalid, exp_fault, exp_faddr, exp_rdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < c_DEPTH; i++) model[i] = 8'(i);
    exp_rdata = '0; exp_faddr = '0; exp_rvalid = 1'b0; exp_fault = 1'b0;
    test_reset();
    test_load_init();
    test_byte_store();
    test_misalign();
    test_read_first();
    test_bounds();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
